serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_sub_pkg.sv | 20 ++
 rtl/full_subtractor.sv | 21 ++
 rtl/serial_subtractor.sv | 150 +++++++++++++++
 tb/tb_serial_subtractor.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// ============================================================================
// Module : serial_sub_pkg
// Brief  : Shared FSM state type and default width for the serial subtractor.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package serial_sub_pkg;

    localparam int c_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sub_state_e;

endpackage : serial_sub_pkg

`default_nettype wire

// File: rtl/full_subtractor.sv
// ============================================================================
// Module : full_subtractor
// Brief  : One-bit combinational difference/borrow cell (a - b - b_in).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic b_in,
    output logic d,
    output logic b_out
);

    assign d     = a ^ b ^ b_in;
    assign b_out = (~a & b) | (~(a ^ b) & b_in);

endmodule : full_subtractor

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
// Module : serial_subtractor
// Brief  : Bit-serial a-b, LSB first, one bit per clock; borrow and signed
//          overflow flags. Define SERIAL_SUB_SAT_EN to clamp diff to 0 on borrow.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf
);

    localparam int unsigned             c_CNT_W = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0]      c_LAST  = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0]      c_ONE   = c_CNT_W'(1);

    sub_state_e           state_q, state_d;
    logic [c_CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]     a_sh_q, a_sh_d;
    logic [WIDTH-1:0]     b_sh_q, b_sh_d;
    logic [WIDTH-2:0]     res_q, res_d;
    logic                 br_q, br_d;
    logic                 a_msb_q, a_msb_d;
    logic                 b_msb_q, b_msb_d;
    logic [WIDTH-1:0]     diff_q, diff_d;
    logic                 borrow_q, borrow_d;
    logic                 ovf_q, ovf_d;

    logic                 w_d;
    logic                 w_b_out;
    logic [WIDTH-1:0]     w_res_full;

    full_subtractor u_fs (
        .a     (a_sh_q[0]),
        .b     (b_sh_q[0]),
        .b_in  (br_q),
        .d     (w_d),
        .b_out (w_b_out)
    );

    // The result register keeps only WIDTH-1 bits: the final bit goes
    // straight from the cell into diff on the edge that enters DONE.
    assign w_res_full = {w_d, res_q};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_d    = res_q;
        br_d     = br_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
                    res_d   = '0;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
                res_d  = w_res_full[WIDTH-1:1];
                br_d   = w_b_out;
                cnt_d  = cnt_q + c_ONE;
                if (cnt_q == c_LAST) begin
                    state_d  = DONE;
                    borrow_d = w_b_out;
                    // Overflow uses the unclamped MSB of the difference.
                    ovf_d    = (a_msb_q != b_msb_q) && (w_d != a_msb_q);
`ifdef SERIAL_SUB_SAT_EN
                    diff_d   = w_b_out ? '0 : w_res_full;
`else
                    diff_d   = w_res_full;
`endif
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_q    <= '0;
            br_q     <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_q    <= res_d;
            br_q     <= br_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign diff   = diff_q;
    assign borrow = borrow_q;
    assign ovf    = ovf_q;

endmodule : serial_subtractor

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================================
// Module : tb_serial_subtractor
// Brief  : Self-checking bench: arithmetic reference model compared every
//          cycle, plus directed literal cases and random stimulus.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy, done, borrow, ovf;
    logic [W-1:0] diff;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow),
        .ovf    (ovf)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (edge-indexed, plain arithmetic) -----
    int           edge_n  = 0;
    int           e0      = 0;
    bit           have_op = 1'b0;
    logic [W-1:0] pend_diff = '0;
    bit           pend_b = 1'b0, pend_o = 1'b0;
    logic [W-1:0] exp_diff = '0;
    bit           exp_b = 1'b0, exp_o = 1'b0, exp_busy = 1'b0, exp_done = 1'b0;
    int           ai, bi, sa, sb, sd;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            have_op  = 1'b0;
            exp_diff = '0;
            exp_b    = 1'b0;
            exp_o    = 1'b0;
            exp_busy = 1'b0;
            exp_done = 1'b0;
        end else begin
            edge_n++;
            // An operation accepted at edge e0 occupies edges e0+1 .. e0+W+1.
            if (!(have_op && edge_n <= e0 + W + 1) && start) begin
                have_op   = 1'b1;
                e0        = edge_n;
                ai        = int'(a);
                bi        = int'(b);
                sa        = (ai >= (1 << (W - 1))) ? ai - (1 << W) : ai;
                sb        = (bi >= (1 << (W - 1))) ? bi - (1 << W) : bi;
                sd        = sa - sb;
                pend_diff = W'(ai - bi);
                pend_b    = (ai < bi);
                pend_o    = (sd < -(1 << (W - 1))) || (sd > (1 << (W - 1)) - 1);
`ifdef SERIAL_SUB_SAT_EN
                if (pend_b) pend_diff = '0;
`endif
            end
            exp_busy = have_op && (edge_n >= e0) && (edge_n <= e0 + W);
            exp_done = have_op && (edge_n == e0 + W);
            if (exp_done) begin
                exp_diff = pend_diff;
                exp_b    = pend_b;
                exp_o    = pend_o;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy",   32'(busy),   32'(exp_busy));
        chk("done",   32'(done),   32'(exp_done));
        chk("diff",   32'(diff),   32'(exp_diff));
        chk("borrow", 32'(borrow), 32'(exp_b));
        chk("ovf",    32'(ovf),    32'(exp_o));
    end

    // ---------------- stimulus helpers -------------------------------------
    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] v;
        case ($urandom_range(0, 5))
            0:       v = 8'h00;
            1:       v = 8'h7F;
            2:       v = 8'h80;
            3:       v = 8'hFF;
            default: v = W'($urandom);
        endcase
        return v;
    endfunction

    task automatic do_op(input string nm, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [W-1:0] xd, input bit xb, input bit xo);
        int n;
        tick();
        a = av; b = bv; start = 1'b1;
        tick();
        start = 1'b0; a = W'($urandom); b = W'($urandom);
        n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        chk({nm, "_latency"}, 32'(n), 32'(W));
        chk({nm, "_diff"},    32'(diff),   32'(xd));
        chk({nm, "_borrow"},  32'(borrow), 32'(xb));
        chk({nm, "_ovf"},     32'(ovf),    32'(xo));
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_busy"},   32'(busy),   32'd0);
        chk({nm, "_done"},   32'(done),   32'd0);
        chk({nm, "_diff"},   32'(diff),   32'd0);
        chk({nm, "_borrow"}, 32'(borrow), 32'd0);
        chk({nm, "_ovf"},    32'(ovf),    32'd0);
    endtask

    initial begin
        int dones;
        tick();
        tick();
        chk_zero("reset_state");
        rst = 1'b0;

        do_op("op5A_23", 8'h5A, 8'h23, 8'h37, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        #1;
        chk_zero("rst_idle");
        tick();
        rst = 1'b0;

`ifdef SERIAL_SUB_SAT_EN
        do_op("op10_20", 8'h10, 8'h20, 8'h00, 1'b1, 1'b0);
        do_op("op7F_FF", 8'h7F, 8'hFF, 8'h00, 1'b1, 1'b1);
`else
        do_op("op10_20", 8'h10, 8'h20, 8'hF0, 1'b1, 1'b0);
        do_op("op7F_FF", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
`endif
        do_op("op80_01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        do_op("op00_00", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);

        // start pulsed mid-operation must be ignored
        tick();
        a = 8'h05; b = 8'h03; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        a = 8'hFF; b = 8'h00; start = 1'b1;
        tick();
        start = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            dones += int'(done);
            tick();
        end
        chk("ignore_start_dones", 32'(dones), 32'd1);
        chk("ignore_start_diff",  32'(diff),  32'h02);

        // held start: back-to-back operations
        a = 8'h09; b = 8'h04; start = 1'b1;
        dones = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            dones += int'(done);
        end
        start = 1'b0;
        chk("b2b_dones", 32'(dones), 32'd2);
        for (int i = 0; i < 12; i++) tick();

        // reset on the 4th SHIFT cycle aborts with no done pulse
        a = 8'hAA; b = 8'h11; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk_zero("rst_shift");
        dones = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            dones += int'(done);
        end
        chk("rst_shift_dones", 32'(dones), 32'd0);
        rst = 1'b0;
        do_op("op01_01", 8'h01, 8'h01, 8'h00, 1'b0, 1'b0);

        // random traffic, occasional resets, checked every cycle by the model
        for (int i = 0; i < 600; i++) begin
            tick();
            start = ($urandom_range(0, 2) == 0);
            a     = pick();
            b     = pick();
            rst   = ($urandom_range(0, 99) == 0);
        end
        rst   = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 15; i++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_serial_subtractor

`default_nettype wire
